mc_control_unit: RTL
====================

# mc_control_unit

Multicycle main control FSM for the MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states. It reads the opcode field held in the instruction register and drives all datapath strobes and mux selects, including the instruction-register load strobe. It handles a variable-latency memory through a `mem_ready` handshake.

## Interface
Parameters:
- none. Opcode and state encodings come from the shared package.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clock` rising edge
- `opcode`  in  6  instruction[31:26] from the instruction register
- `mem_ready`  in  1  memory completed the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load qualified by ALU zero (beq)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode
- `state`  out  4  current state, for debug/trace

## Operation
Supported opcodes:
- R-type 0x00
- lw 0x23
- sw 0x2B
- beq 0x04
- addi 0x08
- j 0x02

States and transitions:
- **FETCH**
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle `mem_ready`=1; the FSM then goes to DECODE. Otherwise it stays in FETCH.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEM_ADDR, R-type → R_EXEC, beq → BRANCH, addi → ADDI_EXEC, j → JUMP.
  - Any other opcode pulses `illegal_op` and returns to FETCH.
- **MEM_ADDR**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: lw → MEM_READ, sw → MEM_WRITE.
- **MEM_READ**
  - Outputs: `mem_read`=1, `i_or_d`=1.
  - Holds until `mem_ready`, then goes to MEM_WB.
- **MEM_WB**
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - Next state: FETCH.
- **MEM_WRITE**
  - Outputs: `mem_write`=1, `i_or_d`=1.
  - Holds until `mem_ready`, then goes to FETCH.
- **R_EXEC**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - Next state: R_WB.
- **R_WB**
  - Outputs: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - Next state: FETCH.
- **ADDI_EXEC**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: ADDI_WB.
- **ADDI_WB**
  - Outputs: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - Next state: FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - Next state: FETCH.
- **JUMP**
  - Outputs: `pc_write`=1, `pc_source`=10.
  - Next state: FETCH.

Output rules:
- Any output not listed for a state is 0.
- Outputs are a function of the registered state only. The exceptions are FETCH `ir_write`/`pc_write`, which are additionally gated by `mem_ready`.
- `opcode` is sampled only in DECODE and MEM_ADDR. It is stable there because `ir_write` is low outside FETCH.

## Timing
- **Reset:** while `reset`=1 at a rising edge, the state becomes FETCH. While `reset` is high, all strobes (`pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `illegal_op`) are forced to 0.
- **After reset:** the first cycle after `reset` deasserts is FETCH.
- **Reset mid-instruction:** the instruction is abandoned with no further writes, and the FSM returns to FETCH.
- **Cycles per instruction with `mem_ready` tied high:**
  - R-type 4
  - addi 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - illegal 2
- **Memory wait:** each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. During the wait, `mem_read`/`mem_write` stay asserted and no other strobe fires.
- **`mem_ready` in other states:** it is ignored outside FETCH, MEM_READ and MEM_WRITE.
- **Strobe width:** `ir_write` is high for exactly one cycle per instruction.

## Structure
- **Shared package** (`mips_pkg`) holds:
  - state enum (4-bit)
  - opcode constants
  - `alu_op` and `pc_source` encodings

  The same constants are used by the datapath and the bench.
- **Single module:** registered state plus combinational next-state and output decode. No sub-module.
- **ALU control:** funct decode belongs to the separate sibling `alu_control`, not inside this block.

## Test plan
- **Reset and fetch:** reset held 3 cycles, then released with `mem_ready`=1 and opcode 0x00.
  - → `state` is FETCH during reset and all strobes are 0.
  - → first post-reset cycle: `ir_write`=1 and `pc_write`=1.
  - → state sequence FETCH, DECODE, R_EXEC, R_WB; `reg_write`=1 with `reg_dst`=1 in cycle 4.
- **lw with memory wait:** opcode 0x23, `mem_ready` low for 2 cycles in MEM_READ.
  - → 7 cycles total.
  - → `mem_read`=1 and `i_or_d`=1 throughout MEM_READ.
  - → `reg_write`=1 with `mem_to_reg`=1 exactly once.
- **Store and branch:**
  - sw 0x2B with `mem_ready`=1 → 4 cycles, `mem_write`=1 for one cycle, `reg_write` never 1.
  - beq 0x04 → 3 cycles, `pc_write_cond`=1 with `alu_op`=01 and `pc_source`=01 in cycle 3.
- **Jump and illegal opcode:**
  - j 0x02 → `pc_write`=1 with `pc_source`=10 in cycle 3.
  - opcode 0x3F → `illegal_op` pulses in DECODE, then FETCH next cycle with no writes.
- **Reset mid-instruction:** `reset` asserted in MEM_WRITE while `mem_ready`=0.
  - → `mem_write` drops at that cycle.
  - → FETCH next cycle.
  - → no `reg_write`, `pc_write` or `mem_write` until a new FETCH completes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: control FSM state encoding, opcodes, and the
// alu_op / alu_src_b / pc_source mux encodings used by datapath and control.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] ALU_B_REG    = 2'b00;
   localparam logic [1:0] ALU_B_FOUR   = 2'b01;
   localparam logic [1:0] ALU_B_IMM    = 2'b10;
   localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit.sv
// Multicycle MIPS main control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives all datapath strobes.
//
// Memory handshake: mem_read / mem_write are held high for as long as the
// FSM sits in an access state (FETCH, MEM_READ, MEM_WRITE). The access is
// complete in the cycle mem_ready=1; only then does the FSM advance, and in
// FETCH only then do ir_write / pc_write fire. mem_ready is a don't-care in
// every other state.
module mc_control_unit
   import mips_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_q, state_d;

   assign state = state_q;

   // State register; reset returns to FETCH and abandons any instruction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode from the registered state; strobes are
   // squashed while reset is high so an abandoned instruction writes nothing.
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_B_REG;
      alu_op        = ALU_OP_ADD;
      pc_source     = PC_SRC_ALU;
      illegal_op    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ALU_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            alu_src_b = ALU_B_IMM_SH;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
            state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_OP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PC_SRC_JUMP;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_op    = 1'b0;
      end
   end

endmodule
